// File: rtl/selfu_buf.sv
// Select / unsigned max-min functional unit with a DEPTH-entry result buffer.
// The buffer head is offered to CDB and ROB independently and retires once both have taken it.
module selfu_buf #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned ROBID_W = 4,
   parameter int unsigned DEPTH   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    input_transmit,
   input  logic [WIDTH-1:0]        operand,
   input  logic [1:0][WIDTH-1:0]   depvals,
   input  logic [7:0]              wbs,
   input  logic [7:0]              flags,
   input  logic [ROBID_W-1:0]      robid,
   input  logic                    cdb_transmit,
   output logic                    cdb_transmit_out,
   output logic [ROBID_W-1:0]      cdb_id,
   output logic [WIDTH-1:0]        cdb_val,
   input  logic                    rob_transmit,
   output logic [ROBID_W-1:0]      robid_out,
   output logic [7:0]              flags_out,
   output logic [7:0]              wbs_out,
   output logic [WIDTH-1:0]        value_out,
   output logic                    rob_transmit_out,
   output logic                    busy
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [ROBID_W-1:0] robid_q [DEPTH];
   logic [ROBID_W-1:0] robid_d [DEPTH];
   logic [7:0]         flags_q [DEPTH];
   logic [7:0]         flags_d [DEPTH];
   logic [7:0]         wbs_q   [DEPTH];
   logic [7:0]         wbs_d   [DEPTH];
   logic [WIDTH-1:0]   value_q [DEPTH];
   logic [WIDTH-1:0]   value_d [DEPTH];
   logic [DEPTH-1:0]   cdb_pend_q, cdb_pend_d;
   logic [DEPTH-1:0]   rob_pend_q, rob_pend_d;
   logic [PTR_W-1:0]   head_ptr_q, head_ptr_d;
   logic [PTR_W-1:0]   tail_ptr_q, tail_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic             empty;
   logic             push;
   logic             pop;
   logic             cdb_fire;
   logic             rob_fire;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] result;

   assign empty = (count_q == '0);
   assign busy  = (count_q == CNT_W'(DEPTH));

   // Head presentation: registered state only, zeroed when the buffer is empty.
   assign cdb_transmit_out = !empty && cdb_pend_q[head_ptr_q];
   assign rob_transmit_out = !empty && rob_pend_q[head_ptr_q];
   assign cdb_id    = empty ? '0 : robid_q[head_ptr_q];
   assign cdb_val   = empty ? '0 : value_q[head_ptr_q];
   assign robid_out = empty ? '0 : robid_q[head_ptr_q];
   assign flags_out = empty ? '0 : flags_q[head_ptr_q];
   assign wbs_out   = empty ? '0 : wbs_q[head_ptr_q];
   assign value_out = empty ? '0 : value_q[head_ptr_q];

   assign cdb_fire = cdb_transmit && cdb_transmit_out;
   assign rob_fire = rob_transmit && rob_transmit_out;
   assign push     = input_transmit && !busy;
   // Pop once neither sink still owes a transfer after this cycle's handshakes.
   assign pop      = !empty
                     && !(cdb_pend_q[head_ptr_q] && !cdb_fire)
                     && !(rob_pend_q[head_ptr_q] && !rob_fire);

   // Operand resolution and select / compare-select; ties keep a.
   always_comb begin
      op_a = depvals[0];
      op_b = flags[1] ? operand : depvals[1];
      if (!flags[3]) begin
         result = flags[2] ? op_b : op_a;
      end else if (!flags[2]) begin
         result = (op_b > op_a) ? op_b : op_a;
      end else begin
         result = (op_b < op_a) ? op_b : op_a;
      end
   end

   always_comb begin
      robid_d    = robid_q;
      flags_d    = flags_q;
      wbs_d      = wbs_q;
      value_d    = value_q;
      cdb_pend_d = cdb_pend_q;
      rob_pend_d = rob_pend_q;
      head_ptr_d = head_ptr_q;
      tail_ptr_d = tail_ptr_q;
      count_d    = count_q;

      if (cdb_fire) cdb_pend_d[head_ptr_q] = 1'b0;
      if (rob_fire) rob_pend_d[head_ptr_q] = 1'b0;

      if (push) begin
         robid_d[tail_ptr_q]    = robid;
         flags_d[tail_ptr_q]    = flags;
         wbs_d[tail_ptr_q]      = wbs;
         value_d[tail_ptr_q]    = result;
         cdb_pend_d[tail_ptr_q] = ~flags[7];
         rob_pend_d[tail_ptr_q] = 1'b1;
         tail_ptr_d = (tail_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : tail_ptr_q + PTR_W'(1);
      end

      if (pop) begin
         head_ptr_d = (head_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : head_ptr_q + PTR_W'(1);
      end

      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         robid_q    <= '{default: '0};
         flags_q    <= '{default: '0};
         wbs_q      <= '{default: '0};
         value_q    <= '{default: '0};
         cdb_pend_q <= '0;
         rob_pend_q <= '0;
         head_ptr_q <= '0;
         tail_ptr_q <= '0;
         count_q    <= '0;
      end else begin
         robid_q    <= robid_d;
         flags_q    <= flags_d;
         wbs_q      <= wbs_d;
         value_q    <= value_d;
         cdb_pend_q <= cdb_pend_d;
         rob_pend_q <= rob_pend_d;
         head_ptr_q <= head_ptr_d;
         tail_ptr_q <= tail_ptr_d;
         count_q    <= count_d;
      end
   end

endmodule

// File: tb/tb_selfu_buf.sv
// Directed self-checking bench for selfu_buf (WIDTH=8, ROBID_W=4, DEPTH=2).
module tb_selfu_buf;

   logic            clk = 1'b0;
   logic            rst;
   logic            input_transmit;
   logic [7:0]      operand;
   logic [1:0][7:0] depvals;
   logic [7:0]      wbs;
   logic [7:0]      flags;
   logic [3:0]      robid;
   logic            cdb_transmit;
   logic            cdb_transmit_out;
   logic [3:0]      cdb_id;
   logic [7:0]      cdb_val;
   logic            rob_transmit;
   logic [3:0]      robid_out;
   logic [7:0]      flags_out;
   logic [7:0]      wbs_out;
   logic [7:0]      value_out;
   logic            rob_transmit_out;
   logic            busy;

   int vecs = 0;
   int errs = 0;

   selfu_buf #(.WIDTH(8), .ROBID_W(4), .DEPTH(2)) dut (
      .clk(clk), .rst(rst), .input_transmit(input_transmit), .operand(operand),
      .depvals(depvals), .wbs(wbs), .flags(flags), .robid(robid),
      .cdb_transmit(cdb_transmit), .cdb_transmit_out(cdb_transmit_out),
      .cdb_id(cdb_id), .cdb_val(cdb_val), .rob_transmit(rob_transmit),
      .robid_out(robid_out), .flags_out(flags_out), .wbs_out(wbs_out),
      .value_out(value_out), .rob_transmit_out(rob_transmit_out), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one issue for a single edge, then withdraw it.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] imm,
                        input logic [7:0] fl, input logic [3:0] id);
      input_transmit = 1'b1;
      depvals[0] = a;
      depvals[1] = b;
      operand    = imm;
      flags      = fl;
      robid      = id;
      wbs        = {4'h1, id};
      step();
      input_transmit = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      input_transmit = 1'b0; operand = '0; depvals = '0; wbs = '0; flags = '0; robid = '0;
      cdb_transmit = 1'b0; rob_transmit = 1'b0;
      step();
      vecs++; if (cdb_transmit_out !== 1'b0 || rob_transmit_out !== 1'b0) begin errs++;
         $display("FAIL reset_valids got cdb=%b rob=%b exp 0 0", cdb_transmit_out, rob_transmit_out); end
      vecs++; if (busy !== 1'b0 || value_out !== 8'h00 || robid_out !== 4'h0) begin errs++;
         $display("FAIL reset_data got busy=%b val=%h id=%h exp 0 00 0", busy, value_out, robid_out); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_basic();
      cdb_transmit = 1'b1; rob_transmit = 1'b1;
      issue(8'h12, 8'h34, 8'h00, 8'h04, 4'd3);
      vecs++; if (cdb_transmit_out !== 1'b1 || rob_transmit_out !== 1'b1) begin errs++;
         $display("FAIL basic_valids got cdb=%b rob=%b exp 1 1", cdb_transmit_out, rob_transmit_out); end
      vecs++; if (cdb_id !== 4'd3 || cdb_val !== 8'h34) begin errs++;
         $display("FAIL basic_cdb got id=%h val=%h exp 3 34", cdb_id, cdb_val); end
      vecs++; if (robid_out !== 4'd3 || value_out !== 8'h34 || flags_out !== 8'h04 || wbs_out !== 8'h13) begin errs++;
         $display("FAIL basic_rob got id=%h val=%h fl=%h wbs=%h exp 3 34 04 13", robid_out, value_out, flags_out, wbs_out); end
      step();
      vecs++; if (cdb_transmit_out !== 1'b0 || rob_transmit_out !== 1'b0 || value_out !== 8'h00) begin errs++;
         $display("FAIL basic_pop got cdb=%b rob=%b val=%h exp 0 0 00", cdb_transmit_out, rob_transmit_out, value_out); end
   endtask

   task automatic test_modes();
      logic [7:0] a_t   [5] = '{8'h80, 8'h80, 8'h55, 8'h21, 8'h30};
      logic [7:0] b_t   [5] = '{8'h00, 8'h00, 8'h55, 8'h9A, 8'h20};
      logic [7:0] imm_t [5] = '{8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00};
      logic [7:0] fl_t  [5] = '{8'h0A, 8'h0E, 8'h08, 8'h00, 8'h0C};
      logic [7:0] exp_t [5] = '{8'h80, 8'h7F, 8'h55, 8'h21, 8'h20};
      cdb_transmit = 1'b1; rob_transmit = 1'b1;
      for (int i = 0; i < 5; i++) begin
         issue(a_t[i], b_t[i], imm_t[i], fl_t[i], 4'(i + 4));
         vecs++; if (value_out !== exp_t[i] || cdb_val !== exp_t[i]) begin errs++;
            $display("FAIL mode_%0d got val=%h cdb=%h exp %h", i, value_out, cdb_val, exp_t[i]); end
         step();
      end
   endtask

   task automatic test_split();
      cdb_transmit = 1'b0; rob_transmit = 1'b1;
      issue(8'h11, 8'h22, 8'h00, 8'h00, 4'd5);
      vecs++; if (cdb_transmit_out !== 1'b1 || rob_transmit_out !== 1'b1) begin errs++;
         $display("FAIL split_head got cdb=%b rob=%b exp 1 1", cdb_transmit_out, rob_transmit_out); end
      step();
      vecs++; if (cdb_transmit_out !== 1'b1 || rob_transmit_out !== 1'b0 || robid_out !== 4'd5) begin errs++;
         $display("FAIL split_rob_taken got cdb=%b rob=%b id=%h exp 1 0 5", cdb_transmit_out, rob_transmit_out, robid_out); end
      step();
      vecs++; if (cdb_transmit_out !== 1'b1 || rob_transmit_out !== 1'b0) begin errs++;
         $display("FAIL split_hold got cdb=%b rob=%b exp 1 0", cdb_transmit_out, rob_transmit_out); end
      cdb_transmit = 1'b1;
      step();
      vecs++; if (cdb_transmit_out !== 1'b0 || value_out !== 8'h00 || busy !== 1'b0) begin errs++;
         $display("FAIL split_pop got cdb=%b val=%h busy=%b exp 0 00 0", cdb_transmit_out, value_out, busy); end
   endtask

   task automatic test_suppress();
      cdb_transmit = 1'b1; rob_transmit = 1'b0;
      issue(8'h66, 8'h00, 8'h00, 8'h80, 4'd6);
      vecs++; if (cdb_transmit_out !== 1'b0 || rob_transmit_out !== 1'b1 || flags_out !== 8'h80) begin errs++;
         $display("FAIL suppress_head got cdb=%b rob=%b fl=%h exp 0 1 80", cdb_transmit_out, rob_transmit_out, flags_out); end
      step();
      vecs++; if (cdb_transmit_out !== 1'b0 || rob_transmit_out !== 1'b1 || value_out !== 8'h66) begin errs++;
         $display("FAIL suppress_wait got cdb=%b rob=%b val=%h exp 0 1 66", cdb_transmit_out, rob_transmit_out, value_out); end
      rob_transmit = 1'b1;
      step();
      vecs++; if (rob_transmit_out !== 1'b0 || value_out !== 8'h00) begin errs++;
         $display("FAIL suppress_pop got rob=%b val=%h exp 0 00", rob_transmit_out, value_out); end
   endtask

   task automatic test_full();
      cdb_transmit = 1'b0; rob_transmit = 1'b0;
      issue(8'h01, 8'h00, 8'h00, 8'h00, 4'd1);
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL full_one got busy=%b exp 0", busy); end
      issue(8'h02, 8'h00, 8'h00, 8'h00, 4'd2);
      vecs++; if (busy !== 1'b1 || robid_out !== 4'd1) begin errs++;
         $display("FAIL full_two got busy=%b id=%h exp 1 1", busy, robid_out); end
      issue(8'h03, 8'h00, 8'h00, 8'h00, 4'd3);
      cdb_transmit = 1'b1; rob_transmit = 1'b1;
      step();
      vecs++; if (robid_out !== 4'd2 || busy !== 1'b0) begin errs++;
         $display("FAIL full_order got id=%h busy=%b exp 2 0", robid_out, busy); end
      step();
      vecs++; if (cdb_transmit_out !== 1'b0 || robid_out !== 4'd0) begin errs++;
         $display("FAIL full_drop got cdb=%b id=%h exp 0 0", cdb_transmit_out, robid_out); end
      // Refill, then push into a full buffer on the same edge as a pop.
      cdb_transmit = 1'b0; rob_transmit = 1'b0;
      issue(8'h01, 8'h00, 8'h00, 8'h00, 4'd1);
      issue(8'h02, 8'h00, 8'h00, 8'h00, 4'd2);
      cdb_transmit = 1'b1; rob_transmit = 1'b1;
      issue(8'h04, 8'h00, 8'h00, 8'h00, 4'd4);
      vecs++; if (robid_out !== 4'd2 || busy !== 1'b0) begin errs++;
         $display("FAIL full_poppush got id=%h busy=%b exp 2 0", robid_out, busy); end
      step();
      vecs++; if (cdb_transmit_out !== 1'b0 || robid_out !== 4'd0) begin errs++;
         $display("FAIL full_nobypass got cdb=%b id=%h exp 0 0", cdb_transmit_out, robid_out); end
   endtask

   task automatic test_reset_mid();
      cdb_transmit = 1'b0; rob_transmit = 1'b0;
      issue(8'h07, 8'h00, 8'h00, 8'h00, 4'd7);
      issue(8'h08, 8'h00, 8'h00, 8'h00, 4'd8);
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rmid_full got busy=%b exp 1", busy); end
      cdb_transmit = 1'b1;
      #2 rst = 1'b0;
      #1;
      vecs++; if (busy !== 1'b0 || cdb_transmit_out !== 1'b0 || rob_transmit_out !== 1'b0) begin errs++;
         $display("FAIL rmid_valids got busy=%b cdb=%b rob=%b exp 0 0 0", busy, cdb_transmit_out, rob_transmit_out); end
      vecs++; if (robid_out !== 4'd0 || value_out !== 8'h00 || flags_out !== 8'h00 || wbs_out !== 8'h00) begin errs++;
         $display("FAIL rmid_data got id=%h val=%h fl=%h wbs=%h exp 0", robid_out, value_out, flags_out, wbs_out); end
      #3 rst = 1'b1;
      cdb_transmit = 1'b0;
      step();
      issue(8'h09, 8'h00, 8'h00, 8'h00, 4'd9);
      vecs++; if (robid_out !== 4'd9 || cdb_transmit_out !== 1'b1 || busy !== 1'b0 || value_out !== 8'h09) begin errs++;
         $display("FAIL rmid_restart got id=%h cdb=%b busy=%b val=%h exp 9 1 0 09", robid_out, cdb_transmit_out, busy, value_out); end
      cdb_transmit = 1'b1; rob_transmit = 1'b1;
      step();
      vecs++; if (rob_transmit_out !== 1'b0) begin errs++; $display("FAIL rmid_drain got rob=%b exp 0", rob_transmit_out); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_modes();
      test_split();
      test_suppress();
      test_full();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/selfu_buf.md
Name: selfu_buf

Overview:
Parametrised select functional unit for the out-of-order core, with an internal result buffer. It resolves operands (register or immediate) and computes a plain select, or an unsigned max/min compare-select. Results are queued in a DEPTH-entry FIFO. The FIFO head is offered independently to the CDB and the ROB, and an entry retires only when both sinks have taken it. Issue stalls only when the buffer is full.

Parameters:
WIDTH, 8, data/operand/result width
ROBID_W, 4, ROB tag width
DEPTH, 2, result buffer entries (>=1; need not be a power of 2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
input_transmit  in  1  issue valid; accepted when input_transmit && !busy
operand  in  WIDTH  immediate
depvals  in  2xWIDTH  resolved source values; [0]=a, [1]=reg b
wbs  in  8  writeback selector, passed through
flags  in  8  [0] wb_pc, [1] b=operand when 1, [2] select/min, [3] compare mode, [7] suppress CDB write
robid  in  ROBID_W  ROB tag
cdb_transmit  in  1  CDB grant; transfer when cdb_transmit && cdb_transmit_out
cdb_transmit_out  out  1  head has pending CDB write
cdb_id  out  ROBID_W  head robid
cdb_val  out  WIDTH  head result
rob_transmit  in  1  ROB ack; transfer when rob_transmit && rob_transmit_out
robid_out  out  ROBID_W  head robid
flags_out  out  8  head flags
wbs_out  out  8  head wbs
value_out  out  WIDTH  head result
rob_transmit_out  out  1  head has pending ROB write
busy  out  1  buffer full (count==DEPTH); depends on registered state only

Behaviour:
- Operands: a=depvals[0]; b=flags[1] ? operand : depvals[1].
- Result:
  - flags[3]=0: flags[2] ? b : a.
  - flags[3]=1, flags[2]=0: unsigned max(a,b).
  - flags[3]=1, flags[2]=1: unsigned min(a,b).
  - Ties return a.
- Result is combinational, and is captured into the FIFO tail on accept.
- FIFO entry: robid, flags, wbs, value, cdb_pend, rob_pend.
  - On push: cdb_pend = ~flags[7], rob_pend = 1.
  - Pointers wrap at DEPTH. count is in 0..DEPTH.
- Latency: accepted in cycle N -> head outputs valid in cycle N+1 if the FIFO was empty. There is no combinational input-to-output path.
- Head presentation: cdb_transmit_out = !empty && head.cdb_pend; rob_transmit_out = !empty && head.rob_pend.
- Data outputs show the head entry. They are all 0 when empty.
- CDB transfer clears head.cdb_pend. ROB transfer clears head.rob_pend.
  - Both may occur in the same cycle, in either order across cycles.
  - A sink whose pend bit is clear must not see its transmit_out again for that entry.
- Pop: the head pops at the clock edge where, after that cycle's transfers, both pend bits are 0.
  - This includes a same-cycle CDB+ROB transfer.
  - flags[7]=1 entries need only the ROB transfer.
- Simultaneous push and pop:
  - Not full: count unchanged, both pointers advance.
  - Full: busy=1 refuses the push even if a pop occurs that cycle. No full bypass.
- Outputs never glitch on input changes; they are functions of registers only.
- Ignored inputs: input_transmit while busy is dropped. cdb_transmit/rob_transmit while the matching transmit_out=0 are ignored.
- Reset (rst=0, any time, including mid-transfer):
  - count, pointers and all pend bits cleared.
  - All outputs 0, busy=0.
  - Buffer contents discarded. The first accept after release behaves as from empty.

Test Plan:
- Basic select: rst low then high; issue a=0x12, depvals[1]=0x34, flags=0x04, robid=3; hold cdb_transmit=rob_transmit=1 -> next cycle cdb_transmit_out=1, cdb_id=3, cdb_val=0x34, rob_transmit_out=1, value_out=0x34; following cycle both outputs 0.
- Immediate and compare modes: (a=0x80, operand=0x7F, flags=0x0A) -> value 0x80; same operands with flags=0x0E -> 0x7F; (a=b=0x55, flags=0x08) -> 0x55.
- Split handshake: issue with cdb_transmit=0, rob_transmit=1 -> ROB takes the entry, rob_transmit_out drops, cdb_transmit_out stays 1; raise cdb_transmit 2 cycles later -> entry pops, count 0.
- CDB suppress: flags=0x80 -> cdb_transmit_out never asserts; entry pops on the rob_transmit handshake alone.
- Full/backpressure (DEPTH=2): both sinks held off, issue robids 1,2,3 back-to-back -> busy=1 after the second accept and robid 3 is dropped. Release both sinks -> heads appear in order 1 then 2, busy=0 after the first pop. Pushing while full with a pop in the same cycle -> push refused.
- Reset mid-operation: FIFO holding 2 entries, assert rst low asynchronously between edges -> all outputs 0 immediately, busy=0; after release, a new issue (robid=9) appears as head 1 cycle later.
